// File: rtl/l2_line_memory_if.sv
// Wishbone bundle between the L2 memory-side master and line memory.
// 128-bit line data, 12-bit line address, 16 byte enables.
interface l2_line_memory_if;
  logic [11:0]  ADR;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic [15:0]  SEL;
  logic         STB;
  logic         CYC;
  logic         WE;
  logic         ACK;
  logic         RTY;

  modport master (
    output ADR, DAT_M, SEL, STB, CYC, WE,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  ADR, DAT_M, SEL, STB, CYC, WE,
    output DAT_S, ACK, RTY
  );
endinterface

// File: rtl/l2_line_memory.sv
// Line-granular Wishbone memory model with fixed response latency.
// Define L2_LINE_MEMORY_REFRESH_EN to refuse requests (RTY) in refresh windows.
module l2_line_memory #(
  parameter int LINES          = 4096,
  parameter int LATENCY        = 8,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  l2_line_memory_if.slave  bus
);

  localparam int AW = (LINES > 1) ? $clog2(LINES) : 1;

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("l2_line_memory: LATENCY must be 1..255");
  end
  if (REFRESH_CYCLES >= REFRESH_PERIOD) begin : g_bad_refresh
    $error("l2_line_memory: REFRESH_CYCLES must be < REFRESH_PERIOD");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [11:0]    adr_q;
  logic           we_q;
  logic [15:0]    sel_q;
  logic [127:0]   dat_q;
  logic [127:0]   dat_s_q;
  logic           req;
  logic           refuse;
  logic           accept;
  logic           load_rd;
  logic           do_write;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  wr_idx;
  logic [127:0]   mem [LINES];

  assign req = bus.STB & bus.CYC;

  // Read index comes straight from the bus only on a one-cycle latency.
  assign rd_idx = AW'((32'(state_q == IDLE ? bus.ADR : adr_q)) % LINES);
  assign wr_idx = AW'(32'(adr_q) % LINES);

`ifdef L2_LINE_MEMORY_REFRESH_EN
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  logic [RW-1:0] ref_q;
  logic          rty_q;
  logic          win;

  assign win    = ref_q < RW'(REFRESH_CYCLES);
  assign refuse = win & req & (state_q == IDLE);

  // Free-running refresh phase; window opens right out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
    end else if (ref_q == RW'(REFRESH_PERIOD - 1)) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // One RTY pulse per refused request edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rty_q <= 1'b0;
    end else begin
      rty_q <= refuse;
    end
  end

  assign bus.RTY = rty_q;
`else
  assign refuse  = 1'b0;
  assign bus.RTY = 1'b0;
`endif

  // Next state: accept, count down, respond; CYC low aborts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    load_rd  = 1'b0;
    do_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !refuse) begin
          accept = 1'b1;
          cnt_d  = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            load_rd = ~bus.WE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!bus.CYC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = RESP;
            load_rd = ~we_q;
          end
        end
      end
      RESP: begin
        state_d  = IDLE;
        do_write = we_q & bus.CYC;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, captured request and read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      dat_s_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        adr_q <= bus.ADR;
        we_q  <= bus.WE;
        sel_q <= bus.SEL;
        dat_q <= bus.DAT_M;
      end
      if (load_rd) begin
        dat_s_q <= mem[rd_idx];
      end
    end
  end

  // Byte-masked line write at the ACK edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int i = 0; i < 16; i++) begin
        if (sel_q[i]) begin
          mem[wr_idx][8*i +: 8] <= dat_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.ACK   = (state_q == RESP) & bus.CYC;
  assign bus.DAT_S = dat_s_q;

endmodule
